// File: rtl/tpu_uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divisor helper.
package tpu_uart_pkg;

   localparam int unsigned RX_STATE_W = 3;

   typedef enum logic [RX_STATE_W-1:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BREAK = 3'd4
   } rx_state_e;

   // System clocks per serial bit, integer divide (shared with the TX side).
   function automatic int unsigned clks_per_bit(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy count.
// Ports: clk, rst (sync, active-high), push/push_data, pop,
//        rd_data (head, zero when empty), full, empty, count.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   // A push into a full FIFO is allowed only when a pop frees a slot on the same edge.
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with glitch-rejecting start detection, framing-error
// reporting and a show-ahead byte FIFO.
// Ports: clk, rst (sync, active-high), uart_rx (async line, idle high),
//        rx_data/rx_valid/rx_ready (FIFO head handshake), frame_err and
//        overflow (one-cycle pulses), fifo_count, dbg_state (FSM encoding).
module uart_rx_buffered
   import tpu_uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 100_000_000,
   parameter int unsigned BAUD_RATE  = 115200,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          uart_rx,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          frame_err,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [2:0]                    dbg_state
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int unsigned HALF_CNT     = CLKS_PER_BIT / 2 - 1;
   localparam int unsigned FULL_CNT     = CLKS_PER_BIT - 1;

   logic             sync1_q, sync2_q;
   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             frame_err_q, frame_err_d;
   logic             overflow_q, overflow_d;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;

   assign pop       = rx_ready && !fifo_empty;
   assign rx_valid  = !fifo_empty;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;
   assign dbg_state = state_q;

   // Receiver FSM: mid-bit sampling, counter cleared on every sample.
   always_comb begin
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q + CNT_W'(1);
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      unique case (state_q)
         RX_IDLE: begin
            baud_cnt_d = '0;
            if (!sync2_q) state_d = RX_START;
         end
         RX_START: begin
            if (baud_cnt_q == CNT_W'(HALF_CNT)) begin
               baud_cnt_d = '0;
               bit_idx_d  = '0;
               state_d    = sync2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (baud_cnt_q == CNT_W'(FULL_CNT)) begin
               baud_cnt_d = '0;
               shift_d    = {sync2_q, shift_q[7:1]};
               bit_idx_d  = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (baud_cnt_q == CNT_W'(FULL_CNT)) begin
               baud_cnt_d = '0;
               if (sync2_q) begin
                  push    = 1'b1;
                  state_d = RX_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = RX_BREAK;
               end
            end
         end
         RX_BREAK: begin
            baud_cnt_d = '0;
            if (sync2_q) state_d = RX_IDLE;
         end
         default: begin
            baud_cnt_d = '0;
            state_d    = RX_IDLE;
         end
      endcase
      overflow_d = push && fifo_full && !pop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= RX_IDLE;
         baud_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         sync1_q     <= uart_rx;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (shift_q),
      .pop       (pop),
      .rd_data   (rx_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered at 10 clocks per bit.
module tb_uart_rx_buffered;

   localparam int unsigned CPB = 10;

   logic       clk;
   logic       rst;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overflow;
   logic [3:0] fifo_count;
   logic [2:0] dbg_state;

   uart_rx_buffered #(
      .CLOCK_FREQ (1_000_000),
      .BAUD_RATE  (100_000),
      .FIFO_DEPTH (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .uart_rx    (uart_rx),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .fifo_count (fifo_count),
      .dbg_state  (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int         n_checks = 0;
   int         n_pass   = 0;
   int         fe_cnt   = 0;
   int         ovf_cnt  = 0;
   logic [7:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Observe outputs at the falling edge: pops are scored against the queue.
   task automatic sample_outputs();
      logic [31:0] e;
      if (!rst) begin
         if (rx_valid && rx_ready) begin
            if (exp_q.size() > 0) e = 32'(exp_q.pop_front());
            else e = 32'hDEAD_BEEF;
            check("pop_data", 32'(rx_data), e);
         end
         if (frame_err) fe_cnt++;
         if (overflow) ovf_cnt++;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sample_outputs();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_bit, input bit store);
      if (store) exp_q.push_back(d);
      uart_rx = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         repeat (CPB) tick();
      end
      uart_rx = stop_bit;
      repeat (CPB) tick();
   endtask

   task automatic drain();
      rx_ready = 1'b1;
      for (int i = 0; i < 20 && rx_valid; i++) tick();
      rx_ready = 1'b0;
      tick();
   endtask

   int  fe_base;
   int  ovf_base;
   bit  saw_start;
   bit  found;

   initial begin
      rst      = 1'b1;
      uart_rx  = 1'b1;
      rx_ready = 1'b0;
      repeat (4) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_state", 32'(dbg_state), 0);
      check("rst_valid", 32'(rx_valid), 0);
      check("rst_data", 32'(rx_data), 0);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_ferr", 32'(frame_err), 0);
      check("rst_ovf", 32'(overflow), 0);

      // 1: single frame, held then popped
      fe_base = fe_cnt;
      send_byte(8'hA5, 1'b1, 1'b1);
      check("t1_valid", 32'(rx_valid), 1);
      check("t1_data", 32'(rx_data), 32'hA5);
      check("t1_count", 32'(fifo_count), 1);
      check("t1_ferr", 32'(fe_cnt - fe_base), 0);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check("t1_count_pop", 32'(fifo_count), 0);
      check("t1_data_empty", 32'(rx_data), 0);
      check("t1_valid_empty", 32'(rx_valid), 0);

      // 2: start-bit glitch
      fe_base   = fe_cnt;
      saw_start = 1'b0;
      uart_rx   = 1'b0;
      repeat (3) tick();
      uart_rx = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (dbg_state == 3'd1) saw_start = 1'b1;
         if (saw_start && dbg_state == 3'd0) break;
      end
      check("t2_saw_start", 32'(saw_start), 1);
      check("t2_idle", 32'(dbg_state), 0);
      repeat (20) tick();
      check("t2_count", 32'(fifo_count), 0);
      check("t2_ferr", 32'(fe_cnt - fe_base), 0);

      // 3: bad stop bit followed by a held-low line
      fe_base = fe_cnt;
      send_byte(8'h3C, 1'b0, 1'b0);
      repeat (40) tick();
      check("t3_break", 32'(dbg_state), 4);
      check("t3_ferr_once", 32'(fe_cnt - fe_base), 1);
      check("t3_count", 32'(fifo_count), 0);
      uart_rx = 1'b1;
      repeat (4) tick();
      check("t3_idle", 32'(dbg_state), 0);
      check("t3_ferr_after", 32'(fe_cnt - fe_base), 1);

      // 4: fill past capacity
      ovf_base = ovf_cnt;
      for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1, 1'b1);
      check("t4_count8", 32'(fifo_count), 8);
      check("t4_no_ovf", 32'(ovf_cnt - ovf_base), 0);
      send_byte(8'h08, 1'b1, 1'b0);
      check("t4_ovf", 32'(ovf_cnt - ovf_base), 1);
      check("t4_count_full", 32'(fifo_count), 8);
      check("t4_head", 32'(rx_data), 0);
      drain();
      check("t4_drained_q", 32'(exp_q.size()), 0);
      check("t4_drained_cnt", 32'(fifo_count), 0);

      // 5a: back-to-back frames with consumer ready
      fe_base  = fe_cnt;
      rx_ready = 1'b1;
      send_byte(8'h55, 1'b1, 1'b1);
      send_byte(8'hAA, 1'b1, 1'b1);
      repeat (4) tick();
      rx_ready = 1'b0;
      check("t5_q_empty", 32'(exp_q.size()), 0);
      check("t5_ferr", 32'(fe_cnt - fe_base), 0);

      // 5b: full FIFO, pop coincides with push
      for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1, 1'b1);
      check("t5_full", 32'(fifo_count), 8);
      ovf_base = ovf_cnt;
      found    = 1'b0;
      fork
         send_byte(8'h99, 1'b1, 1'b1);
         begin
            for (int i = 0; i < 120 && !found; i++) begin
               @(posedge clk);
               #1;
               if (dbg_state == 3'd3) found = 1'b1;
            end
            check("t5_stop_seen", 32'(found), 1);
            if (found) begin
               // The stop sample falls on the tenth cycle in STOP.
               repeat (9) begin
                  @(posedge clk);
                  #1;
               end
               rx_ready = 1'b1;
               @(posedge clk);
               #1;
               rx_ready = 1'b0;
            end
         end
      join
      tick();
      check("t5_no_ovf", 32'(ovf_cnt - ovf_base), 0);
      check("t5_count", 32'(fifo_count), 8);
      check("t5_head", 32'(rx_data), 32'h11);
      drain();
      check("t5_drained_q", 32'(exp_q.size()), 0);

      // 6: reset in the middle of a frame
      send_byte(8'h42, 1'b1, 1'b1);
      check("t6_pre_count", 32'(fifo_count), 1);
      uart_rx = 1'b0;
      repeat (CPB) tick();
      uart_rx = 1'b1;
      repeat (4 * CPB + 5) tick();
      check("t6_in_data", 32'(dbg_state), 2);
      rst = 1'b1;
      tick();
      check("t6_rst_state", 32'(dbg_state), 0);
      check("t6_rst_count", 32'(fifo_count), 0);
      check("t6_rst_valid", 32'(rx_valid), 0);
      rst = 1'b0;
      exp_q.delete();
      repeat (60) tick();
      check("t6_no_push", 32'(fifo_count), 0);
      send_byte(8'h81, 1'b1, 1'b1);
      check("t6_count", 32'(fifo_count), 1);
      check("t6_data", 32'(rx_data), 32'h81);
      drain();
      check("t6_drained_q", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
